// File: rtl/bmst_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bmst_pkg
// Description : Shared defaults and helpers for the BMST sliding-window
//               decoder, so the pre-data buffer, the final selector and the
//               decoder core all agree on symbol width and frame geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package bmst_pkg;

  // MSB index of a soft symbol (buses are c_WIDTH_DEFAULT+1 bits wide)
  localparam int c_WIDTH_DEFAULT     = 5;
  // Symbols per frame
  localparam int c_FRAME_LEN_DEFAULT = 16;
  // BMST memory order (frames of delay)
  localparam int c_MEM_DEFAULT       = 2;

  // Ceiling log2 with clog2(1) = 0; usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage : bmst_pkg
`default_nettype wire

// File: rtl/pre_data_ram.sv
`default_nettype none
// ============================================================================
// Module      : pre_data_ram
// Description : Single-port RAM with synchronous read-before-write. When
//               enabled, the addressed word's old contents are registered
//               onto o_rdata and i_wdata is written at the same edge. The
//               read register holds while disabled.
// Revision    : 1.0 - initial release
// Ports       : clk      - rising-edge clock
//               rst_n    - async active-low reset (read register only)
//               i_en     - access enable (read old word + write new word)
//               i_addr   - word address
//               i_wdata  - write data
//               o_rdata  - registered old contents of the accessed word
// ============================================================================
module pre_data_ram
  import bmst_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  // Storage is intentionally not reset; validity is tracked by the caller.
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Non-blocking semantics give read-before-write: the old word is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_en) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule : pre_data_ram
`default_nettype wire

// File: rtl/pre_data_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pre_data_buffer
// Description : Upstream stage of the BMST final selector. Buffers Mem frames
//               of soft symbols and, for every accepted symbol, emits the
//               symbol from the same position Mem frames earlier (Pre_Data)
//               aligned with the current symbol (Cur_Data), plus a Select
//               flag marking Pre_Data as genuine history.
// Revision    : 1.0 - initial release
// Ports       : clk        - rising-edge clock
//               rst_n      - async active-low reset
//               In_Valid   - Input_Data carries a symbol (no backpressure)
//               Input_Data - incoming soft symbol
//               Flush      - synchronous restart of frame/fill tracking
//               Pre_Data   - symbol from Mem frames ago, same position
//               Cur_Data   - Input_Data delayed one cycle
//               Select     - 1 when Pre_Data is valid history
//               Out_Valid  - output beat valid
//               Frame_End  - output beat is the last symbol of a frame
// ============================================================================
module pre_data_buffer
  import bmst_pkg::*;
#(
  parameter int Width     = c_WIDTH_DEFAULT,
  parameter int Frame_Len = c_FRAME_LEN_DEFAULT,
  parameter int Mem       = c_MEM_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         In_Valid,
  input  logic [Width:0] Input_Data,
  input  logic         Flush,
  output logic [Width:0] Pre_Data,
  output logic [Width:0] Cur_Data,
  output logic         Select,
  output logic         Out_Valid,
  output logic         Frame_End
);

  localparam int DEPTH  = Frame_Len * Mem;
  localparam int Addr_W = clog2(DEPTH);
  localparam int POS_W  = clog2(Frame_Len);
  // Keep the slot counter at least one bit wide so Mem=1 still elaborates.
  localparam int SLOT_W = (Mem > 1) ? clog2(Mem) : 1;
  localparam int FILL_W = clog2(Mem + 1);

  localparam logic [POS_W-1:0]  c_POS_LAST  = POS_W'(Frame_Len - 1);
  localparam logic [SLOT_W-1:0] c_SLOT_LAST = SLOT_W'(Mem - 1);
  localparam logic [FILL_W-1:0] c_FILL_FULL = FILL_W'(Mem);

  logic [POS_W-1:0]  r_pos;
  logic [SLOT_W-1:0] r_slot;
  logic [FILL_W-1:0] r_filled;
  logic [Width:0]    r_cur;
  logic              r_sel;
  logic              r_valid;
  logic              r_fend;

  logic              w_accept;
  logic              w_pos_last;
  logic              w_full;
  logic [Addr_W-1:0] w_addr;
  logic [Width:0]    w_pre;

  // Flush outranks a simultaneous symbol: it is neither written nor emitted.
  assign w_accept   = In_Valid & ~Flush;
  assign w_pos_last = (r_pos == c_POS_LAST);
  assign w_full     = (r_filled == c_FILL_FULL);
  assign w_addr     = Addr_W'(r_slot) * Addr_W'(Frame_Len) + Addr_W'(r_pos);

  // Frame position, slot rotation and fill level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos    <= '0;
      r_slot   <= '0;
      r_filled <= '0;
    end else if (Flush) begin
      r_pos    <= '0;
      r_slot   <= '0;
      r_filled <= '0;
    end else if (In_Valid) begin
      if (w_pos_last) begin
        r_pos  <= '0;
        r_slot <= (r_slot == c_SLOT_LAST) ? '0 : r_slot + 1'b1;
        if (!w_full) begin
          r_filled <= r_filled + 1'b1;
        end
      end else begin
        r_pos <= r_pos + 1'b1;
      end
    end
  end

  // Output registers; data and Select hold while no symbol is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur   <= '0;
      r_sel   <= 1'b0;
      r_valid <= 1'b0;
      r_fend  <= 1'b0;
    end else begin
      r_valid <= w_accept;
      r_fend  <= w_accept & w_pos_last;
      if (w_accept) begin
        r_cur <= Input_Data;
        r_sel <= w_full;
      end
    end
  end

  pre_data_ram #(
    .DATA_W (Width + 1),
    .DEPTH  (DEPTH),
    .ADDR_W (Addr_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_accept),
    .i_addr  (w_addr),
    .i_wdata (Input_Data),
    .o_rdata (w_pre)
  );

  assign Pre_Data  = w_pre;
  assign Cur_Data  = r_cur;
  assign Select    = r_sel;
  assign Out_Valid = r_valid;
  assign Frame_End = r_fend;

endmodule : pre_data_buffer
`default_nettype wire
